vector_mem_sequencer: RTL

Sequences vector memory instructions (ldrv/strv, MemSrc=1) over the single 32-bit data-memory port in the memory stage. A 128-bit vector access becomes four consecutive word beats, and the pipeline is stalled while they run. Scalar accesses (str/ldr, MemSrc=0) pass straight through in one cycle. The block sits between the memory-stage control/data signals and the data memory, and feeds Stall to the hazard logic.

---
 rtl/vector_mem_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: memory-stage sequencer splitting 128-bit vector
// accesses into four 32-bit word beats; scalar accesses pass through.
// Ports: clk, rst_n | MemReq, MemW, MemSrc, Addr, WriteData, WriteDataV,
//   MemRD (async read data) | MemAddr, MemWE, MemWD to data memory |
//   ReadData, ReadDataV results | Stall, Busy, Done status.
module vector_mem_sequencer #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         MemReq,
  input  logic         MemW,
  input  logic         MemSrc,
  input  logic [31:0]  Addr,
  input  logic [31:0]  WriteData,
  input  logic [127:0] WriteDataV,
  input  logic [31:0]  MemRD,
  output logic [31:0]  MemAddr,
  output logic         MemWE,
  output logic [31:0]  MemWD,
  output logic [31:0]  ReadData,
  output logic [127:0] ReadDataV,
  output logic         Stall,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  k;
  logic [31:0] base;
  logic        we_q;
  logic [95:0] wd_q;
  logic        vec_start;
  logic [31:0] lane_wd;

  assign vec_start = (state == IDLE)
                   & MemReq & MemSrc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= 2'd0;
      base      <= 32'd0;
      we_q      <= 1'b0;
      wd_q      <= 96'd0;
      ReadDataV <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (vec_start) begin
            base  <= {Addr[31:2], 2'b00};
            we_q  <= MemW;
            wd_q  <= WriteDataV[127:32];
            if (!MemW)
              ReadDataV[31:0] <= MemRD;
            k     <= 2'd1;
            state <= BEAT;
          end
        end
        BEAT: begin
          if (!we_q)
            ReadDataV[{k, 5'b0} +: 32] <= MemRD;
          if (k == 2'd3) begin
            k     <= 2'd0;
            state <= DONE;
          end else begin
            k <= k + 2'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    lane_wd = wd_q[95:64];
    unique case (k)
      2'd1:    lane_wd = wd_q[31:0];
      2'd2:    lane_wd = wd_q[63:32];
      default: lane_wd = wd_q[95:64];
    endcase
  end

  always_comb begin
    MemAddr = Addr;
    MemWE   = 1'b0;
    MemWD   = WriteData;
    Stall   = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (vec_start) begin
          MemAddr = {Addr[31:2], 2'b00};
          MemWE   = MemW;
          MemWD   = WriteDataV[31:0];
          Stall   = 1'b1;
        end else if (MemReq) begin
          MemWE = MemW;
        end
      end
      (state == BEAT): begin
        MemAddr = base + {28'd0, k, 2'b00};
        MemWE   = we_q;
        MemWD   = lane_wd;
        Stall   = 1'b1;
      end
      default: ;
    endcase
    // Reset must kill writes and stalls at once, even with MemReq held.
    if (!rst_n) begin
      MemWE = 1'b0;
      Stall = 1'b0;
    end
  end

  assign ReadData = MemRD;
  assign Busy     = (state != IDLE);
  assign Done     = (state == DONE);

endmodule
